// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV32IM memory-access stage: ALU writeback or load/store bus access
//
// Ports:
//   clock, reset_n                 single clock, asynchronous active-low reset
//   in_valid/in_ready              upstream handshake (ready only while IDLE)
//   alu_result, store_data,        ALU result / effective address, rs2, access
//   funct3, mem_read, mem_write,   size+sign, op kind (mem_read wins), rd and
//   rd, reg_write                  its write enable
//   bus_req/bus_ack                data-bus request held until ack
//   bus_we, bus_addr, bus_wdata,   word-aligned address, lane-replicated store
//   bus_wstrb, bus_rdata           data, byte strobes, load word
//   wb_valid, wb_rd, wb_we,        one registered retire beat per instruction
//   wb_data, misaligned
//
// Optional feature: define MEM_MISALIGN_TRAP_EN to retire misaligned H/W
// accesses immediately with misaligned=1 instead of issuing a bus transfer.

module mem_stage (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [2:0]  funct3,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [4:0]  rd,
    input  logic        reg_write,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_we,
    output logic [31:0] wb_data,
    output logic        misaligned
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [4:0]  rd_q, rd_d;
    logic        reg_write_q, reg_write_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_wstrb_q, bus_wstrb_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_we_q, wb_we_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        misaligned_q, misaligned_d;

    logic        is_mem;
    logic        misalign_in;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign is_mem = mem_read | mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
    // funct3[1:0]: 00 byte, 01 half, 1x word (011/110/111 behave as word).
    assign misalign_in = ((funct3[1:0] == 2'b01) && alu_result[0]) ||
                         (funct3[1] && (alu_result[1:0] != 2'b00));
`else
    assign misalign_in = 1'b0;
`endif

    // Store lane steering from the incoming address; offsets finer than
    // the access size are dropped.
    always_comb begin
        st_wstrb = 4'b1111;
        st_wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                st_wstrb = 4'b0001 << alu_result[1:0];
                st_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                st_wstrb = alu_result[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{store_data[15:0]}};
            end
            default: begin
                st_wstrb = 4'b1111;
                st_wdata = store_data;
            end
        endcase
    end

    // Load extraction from the latched address; funct3[2] selects zero-extend.
    always_comb begin
        ld_half = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (addr_q[1:0])
            2'b00:   ld_byte = bus_rdata[7:0];
            2'b01:   ld_byte = bus_rdata[15:8];
            2'b10:   ld_byte = bus_rdata[23:16];
            default: ld_byte = bus_rdata[31:24];
        endcase
        case (funct3_q[1:0])
            2'b00:   ld_data = funct3_q[2] ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = funct3_q[2] ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = bus_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        funct3_d     = funct3_q;
        rd_d         = rd_q;
        reg_write_d  = reg_write_q;
        bus_we_d     = bus_we_q;
        bus_wdata_d  = bus_wdata_q;
        bus_wstrb_d  = bus_wstrb_q;
        wb_valid_d   = 1'b0;
        wb_rd_d      = wb_rd_q;
        wb_we_d      = 1'b0;
        wb_data_d    = wb_data_q;
        misaligned_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (!is_mem) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd;
                        wb_we_d    = reg_write && (rd != 5'd0);
                        wb_data_d  = alu_result;
                    end else if (misalign_in) begin
                        // Trap beat carries the faulting address, no bus traffic.
                        wb_valid_d   = 1'b1;
                        wb_rd_d      = rd;
                        wb_data_d    = alu_result;
                        misaligned_d = 1'b1;
                    end else begin
                        addr_d      = alu_result;
                        funct3_d    = funct3;
                        rd_d        = rd;
                        reg_write_d = reg_write;
                        bus_we_d    = ~mem_read;
                        bus_wstrb_d = mem_read ? 4'b0000 : st_wstrb;
                        bus_wdata_d = mem_read ? 32'd0 : st_wdata;
                        state_d     = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                if (bus_ack) begin
                    state_d    = S_IDLE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    if (bus_we_q) begin
                        wb_data_d = 32'd0;
                    end else begin
                        wb_data_d = ld_data;
                        wb_we_d   = reg_write_q && (rd_q != 5'd0);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            addr_q       <= 32'd0;
            funct3_q     <= 3'd0;
            rd_q         <= 5'd0;
            reg_write_q  <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_wdata_q  <= 32'd0;
            bus_wstrb_q  <= 4'd0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= 5'd0;
            wb_we_q      <= 1'b0;
            wb_data_q    <= 32'd0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            funct3_q     <= funct3_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            bus_we_q     <= bus_we_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_wstrb_q  <= bus_wstrb_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_q      <= wb_rd_d;
            wb_we_q      <= wb_we_d;
            wb_data_q    <= wb_data_d;
            misaligned_q <= misaligned_d;
        end
    end

    // bus_req follows the state flop, so reset drops it asynchronously.
    assign in_ready   = (state_q == S_IDLE);
    assign bus_req    = (state_q == S_ACCESS);
    assign bus_we     = bus_we_q;
    assign bus_addr   = {addr_q[31:2], 2'b00};
    assign bus_wdata  = bus_wdata_q;
    assign bus_wstrb  = bus_wstrb_q;
    assign wb_valid   = wb_valid_q;
    assign wb_rd      = wb_rd_q;
    assign wb_we      = wb_we_q;
    assign wb_data    = wb_data_q;
    assign misaligned = misaligned_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage
module tb_mem_stage;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] alu_result = '0;
    logic [31:0] store_data = '0;
    logic [2:0]  funct3 = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [4:0]  rd = '0;
    logic        reg_write = 1'b0;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        wb_valid, wb_we, misaligned;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int pass_cnt = 0;
    int total_cnt = 0;

    mem_stage dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .store_data(store_data), .funct3(funct3),
        .mem_read(mem_read), .mem_write(mem_write), .rd(rd), .reg_write(reg_write),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_wstrb(bus_wstrb), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
        .misaligned(misaligned)
    );

    always #5 clock = ~clock;

    // Reference model: access size in bytes, aligned offset, lane math.
    function automatic int m_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic int m_off(input logic [2:0] f3, input logic [31:0] a);
        int lo;
        lo = int'(a[1:0]);
        return lo - (lo % m_size(f3));
    endfunction

    function automatic logic [3:0] m_wstrb(input logic [2:0] f3, input logic [31:0] a);
        int v;
        v = ((1 << m_size(f3)) - 1) << m_off(f3, a);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = sd[8*(b % m_size(f3)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
        longint v;
        int s;
        s = m_size(f3);
        v = (longint'({32'd0, w}) >> (8 * m_off(f3, a))) & ((longint'(1) << (8 * s)) - 1);
        if (!f3[2] && s < 4 && v[8*s-1]) v = v - (longint'(1) << (8 * s));
        return v[31:0];
    endfunction

    // Drives one memory op, acks it after 'delay' idle ACCESS cycles and
    // returns what was observed on the bus and on the writeback beat.
    task automatic run_mem(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] sd, input logic [31:0] rdata,
                           input logic [4:0] rdi, input logic rw, input int delay,
                           output logic [31:0] o_addr, output logic [31:0] o_wdata,
                           output logic [3:0] o_wstrb, output logic o_we,
                           output logic o_access_ok, output logic o_wbv,
                           output logic o_wbwe, output logic o_mis,
                           output logic [4:0] o_wbrd, output logic [31:0] o_wbdata,
                           output logic o_rdy);
        in_valid = 1'b1; alu_result = addr; store_data = sd; funct3 = f3;
        mem_read = ld; mem_write = ~ld; rd = rdi; reg_write = rw;
        bus_rdata = $urandom;
        @(negedge clock);
        in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        o_addr = bus_addr; o_wdata = bus_wdata; o_wstrb = bus_wstrb; o_we = bus_we;
        o_access_ok = bus_req && !in_ready && !wb_valid;
        for (int i = 0; i < delay; i++) begin
            @(negedge clock);
            bus_rdata = $urandom;
            if (!bus_req || wb_valid || bus_addr !== o_addr || bus_wdata !== o_wdata ||
                bus_wstrb !== o_wstrb || bus_we !== o_we) o_access_ok = 1'b0;
        end
        bus_ack = 1'b1; bus_rdata = rdata;
        @(negedge clock);
        bus_ack = 1'b0; bus_rdata = $urandom;
        o_wbv = wb_valid; o_wbwe = wb_we; o_mis = misaligned;
        o_wbrd = wb_rd; o_wbdata = wb_data; o_rdy = in_ready;
    endtask

    logic [31:0] r_addr, r_wdata, r_wbdata;
    logic [3:0]  r_wstrb;
    logic        r_we, r_ok, r_wbv, r_wbwe, r_mis, r_rdy;
    logic [4:0]  r_wbrd;

    task automatic test_reset();
        @(negedge clock);
        @(negedge clock);
        total_cnt++; if ({bus_req, bus_we, bus_wstrb, wb_valid, wb_we, misaligned} !== 9'd0) $display("FAIL reset_ctrl: got %b exp 0", {bus_req, bus_we, bus_wstrb, wb_valid, wb_we, misaligned}); else pass_cnt++;
        total_cnt++; if ({bus_addr, bus_wdata, wb_rd, wb_data} !== 101'd0) $display("FAIL reset_data: got %h exp 0", {bus_addr, bus_wdata, wb_rd, wb_data}); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b exp 1", in_ready); else pass_cnt++;
        reset_n = 1'b1;
        // Stray ack while idle must be ignored.
        bus_ack = 1'b1;
        @(negedge clock);
        bus_ack = 1'b0;
        total_cnt++; if (wb_valid !== 1'b0 || bus_req !== 1'b0) $display("FAIL idle_ack: got v=%b req=%b exp 0 0", wb_valid, bus_req); else pass_cnt++;
    endtask

    task automatic test_alu_op();
        logic [31:0] e_data;
        logic [4:0]  e_rd;
        logic        e_we;
        in_valid = 1'b1; alu_result = 32'h0000_1234; rd = 5'd5; reg_write = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        total_cnt++; if ({wb_valid, wb_rd, wb_we, wb_data} !== {1'b1, 5'd5, 1'b1, 32'h1234}) $display("FAIL alu_rd5: got v=%b rd=%0d we=%b d=%h exp 1 5 1 00001234", wb_valid, wb_rd, wb_we, wb_data); else pass_cnt++;
        in_valid = 1'b1; rd = 5'd0;
        @(negedge clock);
        in_valid = 1'b0;
        total_cnt++; if ({wb_valid, wb_we, wb_data} !== {1'b1, 1'b0, 32'h1234}) $display("FAIL alu_rd0: got v=%b we=%b d=%h exp 1 0 00001234", wb_valid, wb_we, wb_data); else pass_cnt++;
        @(negedge clock);
        total_cnt++; if (wb_valid !== 1'b0) $display("FAIL alu_single_pulse: got %b exp 0", wb_valid); else pass_cnt++;
        // Back-to-back ALU stream at one op per cycle.
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; alu_result = $urandom; rd = 5'($urandom); reg_write = 1'($urandom);
            e_data = alu_result; e_rd = rd; e_we = reg_write && (rd != 5'd0);
            @(negedge clock);
            in_valid = 1'b0;
            total_cnt++; if ({wb_valid, wb_rd, wb_we, wb_data} !== {1'b1, e_rd, e_we, e_data}) $display("FAIL alu_stream%0d: got %b/%0d/%b/%h exp 1/%0d/%b/%h", i, wb_valid, wb_rd, wb_we, wb_data, e_rd, e_we, e_data); else pass_cnt++;
        end
        @(negedge clock);
    endtask

    task automatic test_store();
        run_mem(1'b0, 3'b000, 32'h103, 32'hAABBCC80, 32'h0, 5'd7, 1'b0, 3,
                r_addr, r_wdata, r_wstrb, r_we, r_ok, r_wbv, r_wbwe, r_mis, r_wbrd, r_wbdata, r_rdy);
        total_cnt++; if (r_addr !== 32'h100) $display("FAIL sb_addr: got %h exp 00000100", r_addr); else pass_cnt++;
        total_cnt++; if (r_wstrb !== 4'b1000) $display("FAIL sb_wstrb: got %b exp 1000", r_wstrb); else pass_cnt++;
        total_cnt++; if (r_wdata !== 32'h80808080) $display("FAIL sb_wdata: got %h exp 80808080", r_wdata); else pass_cnt++;
        total_cnt++; if (r_we !== 1'b1 || r_ok !== 1'b1) $display("FAIL sb_access: got we=%b ok=%b exp 1 1", r_we, r_ok); else pass_cnt++;
        total_cnt++; if ({r_wbv, r_wbwe, r_wbdata} !== {1'b1, 1'b0, 32'd0}) $display("FAIL sb_retire: got v=%b we=%b d=%h exp 1 0 0", r_wbv, r_wbwe, r_wbdata); else pass_cnt++;
        @(negedge clock);
    endtask

    task automatic test_loads();
        logic [2:0]  f3s [3] = '{3'b000, 3'b100, 3'b101};
        logic [31:0] exps [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_1280};
        for (int i = 0; i < 3; i++) begin
            run_mem(1'b1, f3s[i], 32'h102, 32'h0, 32'h1280_3456, 5'd9, 1'b1, i,
                    r_addr, r_wdata, r_wstrb, r_we, r_ok, r_wbv, r_wbwe, r_mis, r_wbrd, r_wbdata, r_rdy);
            total_cnt++; if ({r_addr, r_wstrb, r_we, r_ok} !== {32'h100, 4'b0000, 1'b0, 1'b1}) $display("FAIL load%0d_bus: got a=%h s=%b we=%b ok=%b exp 100 0000 0 1", i, r_addr, r_wstrb, r_we, r_ok); else pass_cnt++;
            total_cnt++; if ({r_wbv, r_wbwe, r_wbrd, r_wbdata} !== {1'b1, 1'b1, 5'd9, exps[i]}) $display("FAIL load%0d_wb: got v=%b we=%b rd=%0d d=%h exp 1 1 9 %h", i, r_wbv, r_wbwe, r_wbrd, r_wbdata, exps[i]); else pass_cnt++;
        end
        run_mem(1'b1, 3'b010, 32'h200, 32'h0, 32'hDEAD_BEEF, 5'd0, 1'b1, 1,
                r_addr, r_wdata, r_wstrb, r_we, r_ok, r_wbv, r_wbwe, r_mis, r_wbrd, r_wbdata, r_rdy);
        total_cnt++; if ({r_ok, r_wbv, r_wbwe} !== 3'b110) $display("FAIL load_rd0: got ok=%b v=%b we=%b exp 1 1 0", r_ok, r_wbv, r_wbwe); else pass_cnt++;
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        run_mem(1'b1, 3'b010, 32'h40, 32'h0, 32'h0BAD_F00D, 5'd3, 1'b1, 0,
                r_addr, r_wdata, r_wstrb, r_we, r_ok, r_wbv, r_wbwe, r_mis, r_wbrd, r_wbdata, r_rdy);
        total_cnt++; if ({r_wbv, r_rdy, r_wbdata} !== {1'b1, 1'b1, 32'h0BAD_F00D}) $display("FAIL b2b_load: got v=%b rdy=%b d=%h exp 1 1 0badf00d", r_wbv, r_rdy, r_wbdata); else pass_cnt++;
        in_valid = 1'b1; alu_result = 32'h5555_0001; rd = 5'd4; reg_write = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        total_cnt++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd4, 32'h5555_0001}) $display("FAIL b2b_next: got v=%b rd=%0d d=%h exp 1 4 55550001", wb_valid, wb_rd, wb_data); else pass_cnt++;
        @(negedge clock);
        total_cnt++; if (wb_valid !== 1'b0) $display("FAIL b2b_dup: got %b exp 0", wb_valid); else pass_cnt++;
    endtask

    task automatic test_reset_mid_access();
        logic seen_wb;
        in_valid = 1'b1; alu_result = 32'h300; funct3 = 3'b010; mem_read = 1'b1; rd = 5'd6; reg_write = 1'b1;
        @(negedge clock);
        in_valid = 1'b0; mem_read = 1'b0;
        total_cnt++; if (bus_req !== 1'b1) $display("FAIL rst_mid_req_before: got %b exp 1", bus_req); else pass_cnt++;
        #2 reset_n = 1'b0;
        #1;
        total_cnt++; if (bus_req !== 1'b0) $display("FAIL rst_mid_async: got %b exp 0", bus_req); else pass_cnt++;
        bus_ack = 1'b1;
        @(negedge clock);
        bus_ack = 1'b0;
        reset_n = 1'b1;
        seen_wb = wb_valid;
        @(negedge clock);
        seen_wb = seen_wb | wb_valid;
        total_cnt++; if ({seen_wb, bus_req, in_ready} !== 3'b001) $display("FAIL rst_mid_after: got wb=%b req=%b rdy=%b exp 0 0 1", seen_wb, bus_req, in_ready); else pass_cnt++;
    endtask

    task automatic test_misaligned();
`ifdef MEM_MISALIGN_TRAP_EN
        in_valid = 1'b1; alu_result = 32'h102; funct3 = 3'b010; mem_read = 1'b1; rd = 5'd8; reg_write = 1'b1;
        @(negedge clock);
        in_valid = 1'b0; mem_read = 1'b0;
        total_cnt++; if ({bus_req, wb_valid, misaligned, wb_we, in_ready} !== 5'b01101) $display("FAIL trap_flags: got req=%b v=%b mis=%b we=%b rdy=%b exp 0 1 1 0 1", bus_req, wb_valid, misaligned, wb_we, in_ready); else pass_cnt++;
        total_cnt++; if (wb_data !== 32'h102) $display("FAIL trap_data: got %h exp 00000102", wb_data); else pass_cnt++;
        @(negedge clock);
        total_cnt++; if ({bus_req, wb_valid, misaligned} !== 3'b000) $display("FAIL trap_after: got %b exp 000", {bus_req, wb_valid, misaligned}); else pass_cnt++;
`else
        run_mem(1'b1, 3'b010, 32'h102, 32'h0, 32'h1357_9BDF, 5'd8, 1'b1, 1,
                r_addr, r_wdata, r_wstrb, r_we, r_ok, r_wbv, r_wbwe, r_mis, r_wbrd, r_wbdata, r_rdy);
        total_cnt++; if ({r_addr, r_ok} !== {32'h100, 1'b1}) $display("FAIL lw_mis_bus: got a=%h ok=%b exp 100 1", r_addr, r_ok); else pass_cnt++;
        total_cnt++; if ({r_wbv, r_wbwe, r_mis, r_wbdata} !== {3'b110, 32'h1357_9BDF}) $display("FAIL lw_mis_wb: got v=%b we=%b mis=%b d=%h exp 1 1 0 13579bdf", r_wbv, r_wbwe, r_mis, r_wbdata); else pass_cnt++;
        @(negedge clock);
`endif
    endtask

    task automatic test_random();
        logic        ld;
        logic [2:0]  f3;
        logic [31:0] a, sd, rdw, e_data;
        logic [4:0]  rdi;
        for (int i = 0; i < 40; i++) begin
            ld = 1'($urandom);
            f3 = ld ? 3'($urandom) : 3'($urandom_range(0, 2));
            a = $urandom; sd = $urandom; rdw = $urandom; rdi = 5'($urandom);
`ifdef MEM_MISALIGN_TRAP_EN
            a = a & ~(32'(m_size(f3)) - 32'd1);
`endif
            run_mem(ld, f3, a, sd, rdw, rdi, 1'b1, int'($urandom_range(0, 4)),
                    r_addr, r_wdata, r_wstrb, r_we, r_ok, r_wbv, r_wbwe, r_mis, r_wbrd, r_wbdata, r_rdy);
            e_data = ld ? m_load(f3, a, rdw) : 32'd0;
            total_cnt++; if ({r_addr, r_we, r_ok} !== {a & 32'hFFFF_FFFC, ~ld, 1'b1}) $display("FAIL rnd%0d_bus: got a=%h we=%b ok=%b exp %h %b 1", i, r_addr, r_we, r_ok, a & 32'hFFFF_FFFC, ~ld); else pass_cnt++;
            total_cnt++; if (r_wstrb !== (ld ? 4'b0000 : m_wstrb(f3, a))) $display("FAIL rnd%0d_wstrb: got %b exp %b", i, r_wstrb, ld ? 4'b0000 : m_wstrb(f3, a)); else pass_cnt++;
            if (!ld) begin
                total_cnt++; if (r_wdata !== m_wdata(f3, sd)) $display("FAIL rnd%0d_wdata: got %h exp %h", i, r_wdata, m_wdata(f3, sd)); else pass_cnt++;
            end
            total_cnt++; if ({r_wbv, r_wbwe, r_mis, r_wbrd, r_wbdata} !== {1'b1, ld && (rdi != 5'd0), 1'b0, rdi, e_data}) $display("FAIL rnd%0d_wb: got v=%b we=%b mis=%b rd=%0d d=%h exp 1 %b 0 %0d %h", i, r_wbv, r_wbwe, r_mis, r_wbrd, r_wbdata, ld && (rdi != 5'd0), rdi, e_data); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_store();
        test_loads();
        test_back_to_back();
        test_reset_mid_access();
        test_misaligned();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
